alu_sequencer: RTL



---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_sequencer_if.sv | 23 ++
 rtl/alu_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// State codes and opcode constants shared by the ALU sequencer and the ALU calculation datapath.
package alu_pkg;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        INST_POP1    = 4'd1,
        NOP          = 4'd2,
        EXEC         = 4'd3,
        MUL          = 4'd4,
        RESULT_PUSH1 = 4'd5,
        RESULT_PUSH2 = 4'd6,
        INST_POP2    = 4'd7,
        EXEC_DONE    = 4'd8,
        FAULT        = 4'd9
    } alu_state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MUL = 4'hf;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction FIFO head/pop, result FIFO level, multiplier done,
// and the state/opcode drive into the ALU. The master side is the sequencer.
interface alu_sequencer_if #(
    parameter int CNT_W = 5
);
    logic             instq_empty;
    logic [3:0]       instq_opcode;
    logic             instq_rd_en;
    logic [CNT_W-1:0] resultq_cnt;
    logic             mul_done;
    logic [3:0]       state;
    logic [3:0]       opcode;

    modport master (
        input  instq_empty, instq_opcode, resultq_cnt, mul_done,
        output instq_rd_en, state, opcode
    );

    modport slave (
        output instq_empty, instq_opcode, resultq_cnt, mul_done,
        input  instq_rd_en, state, opcode
    );
endinterface

// File: rtl/alu_sequencer.sv
// ALU control FSM: pops opcodes, sequences EXEC/MUL and the two-word result push, flags done/fault.
// Latency: ALU op 5 cycles, NOP 3, MUL 4 + multiplier; all outputs are Moore decodes of registered state.
// Backpressure: stalls in MUL on mul_done; result FIFO without room for two words faults instead of pushing.
// Optional ALU_SEQ_MUL_TIMEOUT_EN: fault when the multiplier does not answer within MUL_TIMEOUT cycles.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int RESULT_DEPTH = 16,
    parameter int CNT_W        = 5,
    parameter int MUL_TIMEOUT  = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   op_start,
    input  logic                   op_clear,
    alu_sequencer_if.master        dp,
    output logic                   op_done,
    output logic                   fault,
    output logic [7:0]             inst_count
);

    if (RESULT_DEPTH >= (1 << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too narrow for RESULT_DEPTH");
    end
    if (MUL_TIMEOUT < 1 || MUL_TIMEOUT > 255) begin : g_timeout_check
        $error("MUL_TIMEOUT must fit the 8-bit MUL counter");
    end

    localparam logic [CNT_W-1:0] SPACE_LIMIT = CNT_W'(RESULT_DEPTH - 2);

    alu_state_t state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic [7:0] count_q, count_d;
    logic       space_ok;
    logic       mul_timeout;

    // Both result words must fit before the push pair starts.
    assign space_ok = (dp.resultq_cnt <= SPACE_LIMIT);

`ifdef ALU_SEQ_MUL_TIMEOUT_EN
    logic [7:0] mul_cnt;

    // Held at zero outside MUL, so it restarts on every MUL entry and counts MUL cycles minus one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              mul_cnt <= '0;
        else if (state_q != MUL)   mul_cnt <= '0;
        else                       mul_cnt <= mul_cnt + 8'd1;
    end

    assign mul_timeout = (state_q == MUL) && (mul_cnt == 8'(MUL_TIMEOUT - 1));
`else
    assign mul_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        count_d  = count_q;
        if (op_clear) begin
            state_d  = IDLE;
            opcode_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_start) state_d = dp.instq_empty ? EXEC_DONE : INST_POP1;
                end
                INST_POP1: begin
                    opcode_d = dp.instq_opcode;
                    if (dp.instq_opcode == OP_NOP)      state_d = NOP;
                    else if (dp.instq_opcode == OP_MUL) state_d = MUL;
                    else                                state_d = EXEC;
                end
                NOP: begin
                    count_d = sat_inc8(count_q);
                    state_d = INST_POP2;
                end
                EXEC: state_d = space_ok ? RESULT_PUSH1 : FAULT;
                MUL: begin
                    // A late mul_done on the timeout cycle still completes normally.
                    if (dp.mul_done)  state_d = space_ok ? RESULT_PUSH1 : FAULT;
                    else if (mul_timeout) state_d = FAULT;
                end
                RESULT_PUSH1: state_d = RESULT_PUSH2;
                RESULT_PUSH2: begin
                    count_d = sat_inc8(count_q);
                    state_d = INST_POP2;
                end
                INST_POP2: state_d = dp.instq_empty ? EXEC_DONE : INST_POP1;
                EXEC_DONE:    state_d = EXEC_DONE;
                FAULT:        state_d = FAULT;
                default:      state_d = FAULT;
            endcase
        end
    end

    assign dp.state       = state_q;
    assign dp.opcode      = opcode_q;
    assign dp.instq_rd_en = (state_q == INST_POP1);
    assign op_done        = (state_q == EXEC_DONE);
    assign fault          = (state_q == FAULT);
    assign inst_count     = count_q;

endmodule
